// File: rtl/sound_pkg.sv
// Shared constants for the sound scheduler: sound codes, the per-source code table and FSM states.
package sound_pkg;

   localparam int unsigned SOUND_WIDTH = 4;

   localparam logic [SOUND_WIDTH-1:0] MONSTER_HIT_SOUND   = 4'b0001;
   localparam logic [SOUND_WIDTH-1:0] FIRE_SOUND          = 4'b0100;
   localparam logic [SOUND_WIDTH-1:0] LEVEL_UP_SOUND      = 4'b1000;
   localparam logic [SOUND_WIDTH-1:0] SPACESHIP_HIT_SOUND = 4'b1101;

   // Indexed by requester id; a higher index means a higher priority.
   localparam logic [SOUND_WIDTH-1:0] SOUND_CODES [4] = '{
      MONSTER_HIT_SOUND, FIRE_SOUND, LEVEL_UP_SOUND, SPACESHIP_HIT_SOUND
   };

   typedef enum logic [1:0] {IDLE, PLAY, GAP} state_e;

endpackage

// File: rtl/sound_priority_encoder.sv
// Picks the highest set index of a request vector; any_valid flags a non-empty vector.
module sound_priority_encoder #(
   parameter int unsigned NUM_REQUESTS = 4
) (
   input  logic [NUM_REQUESTS-1:0]         cand,
   output logic [$clog2(NUM_REQUESTS)-1:0] sel,
   output logic                            any_valid
);

   always_comb begin
      sel       = '0;
      any_valid = |cand;
      for (int i = 0; i < NUM_REQUESTS; i++) begin
         if (cand[i]) sel = ($clog2(NUM_REQUESTS))'(i);
      end
   end

endmodule

// File: rtl/sound_scheduler.sv
// Arbitrates sound requests onto the audio unit: one sound at a time, fixed duration,
// optional silent gap, higher-priority preemption and single-flag queueing per source.
module sound_scheduler
   import sound_pkg::*;
#(
   parameter int unsigned NUM_REQUESTS    = 4,
   parameter int unsigned DURATION_CYCLES = 25_000_000,
   parameter int unsigned GAP_CYCLES      = 2_500_000
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [NUM_REQUESTS-1:0]         sound_requests,
   input  logic                            mute,
   output logic [SOUND_WIDTH-1:0]          sound_signal,
   output logic                            sound_enable,
   output logic [$clog2(NUM_REQUESTS)-1:0] active_id,
   output logic                            busy
);

   localparam int unsigned IW      = $clog2(NUM_REQUESTS);
   localparam int unsigned MAX_CYC = (DURATION_CYCLES > GAP_CYCLES) ? DURATION_CYCLES : GAP_CYCLES;
   localparam int unsigned CW      = $clog2(MAX_CYC + 1);
   localparam logic [CW-1:0] DUR_LOAD = CW'(DURATION_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LOAD = (GAP_CYCLES == 0) ? '0 : CW'(GAP_CYCLES - 1);

   state_e                  state_q, state_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [NUM_REQUESTS-1:0] pend_q, pend_d;
   logic [NUM_REQUESTS-1:0] req_prev_q;
   logic [IW-1:0]           id_q, id_d;
   logic [SOUND_WIDTH-1:0]  sig_q, sig_d;
   logic                    en_q, en_d, busy_q, busy_d;

   logic [NUM_REQUESTS-1:0] req_edge, cand;
   logic [IW-1:0]           cand_sel, edge_sel;
   logic                    cand_any, edge_any;

   assign req_edge = sound_requests & ~req_prev_q;
   assign cand     = pend_q | req_edge;

   sound_priority_encoder #(.NUM_REQUESTS(NUM_REQUESTS)) u_cand_enc (
      .cand      (cand),
      .sel       (cand_sel),
      .any_valid (cand_any)
   );

   // During PLAY only fresh edges may preempt or retrigger; queued ones wait.
   sound_priority_encoder #(.NUM_REQUESTS(NUM_REQUESTS)) u_edge_enc (
      .cand      (req_edge),
      .sel       (edge_sel),
      .any_valid (edge_any)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         pend_q     <= '0;
         req_prev_q <= '0;
         id_q       <= '0;
         sig_q      <= '0;
         en_q       <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         pend_q     <= pend_d;
         req_prev_q <= sound_requests;
         id_q       <= id_d;
         sig_q      <= sig_d;
         en_q       <= en_d;
         busy_q     <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q;
      id_d    = id_q;
      if (mute) begin
         state_d = IDLE;
         cnt_d   = '0;
         pend_d  = '0;
         id_d    = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (cand_any) begin
                  state_d          = PLAY;
                  id_d             = cand_sel;
                  cnt_d            = DUR_LOAD;
                  pend_d           = cand;
                  pend_d[cand_sel] = 1'b0;
               end
            end
            PLAY: begin
               pend_d = pend_q | req_edge;
               if (edge_any && edge_sel >= id_q) begin
                  // Preempt or retrigger; a preempted sound is dropped, never re-queued.
                  id_d             = edge_sel;
                  cnt_d            = DUR_LOAD;
                  pend_d[edge_sel] = 1'b0;
               end else if (cnt_q == '0) begin
                  id_d = '0;
                  if (GAP_CYCLES == 0) begin
                     state_d = IDLE;
                  end else begin
                     state_d = GAP;
                     cnt_d   = GAP_LOAD;
                  end
               end else begin
                  cnt_d = cnt_q - CW'(1);
               end
            end
            GAP: begin
               pend_d = pend_q | req_edge;
               if (cnt_q == '0) state_d = IDLE;
               else             cnt_d   = cnt_q - CW'(1);
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      sig_d  = '0;
      en_d   = 1'b0;
      busy_d = (state_d != IDLE);
      if (state_d == PLAY) begin
         sig_d = SOUND_CODES[id_d];
         en_d  = 1'b1;
      end
   end

   assign sound_signal = sig_q;
   assign sound_enable = en_q;
   assign active_id    = id_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_sound_scheduler.sv
// Scoreboard bench for sound_scheduler with an 8-cycle sound and a 2-cycle gap.
module tb_sound_scheduler;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] sound_requests;
   logic       mute;
   logic [3:0] sound_signal;
   logic       sound_enable;
   logic [1:0] active_id;
   logic       busy;

   int unsigned n_vec = 0;
   int unsigned n_bad = 0;
   string       phase = "init";
   logic [7:0]  exp_q[$];

   always #5 clk = ~clk;

   sound_scheduler #(
      .NUM_REQUESTS    (4),
      .DURATION_CYCLES (8),
      .GAP_CYCLES      (2)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .sound_requests (sound_requests),
      .mute           (mute),
      .sound_signal   (sound_signal),
      .sound_enable   (sound_enable),
      .active_id      (active_id),
      .busy           (busy)
   );

   task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] want);
      n_vec++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got {busy,en,id,sig}=%b, expected %b", tag, got, want);
      end
   endtask

   // Expected post-edge output: {busy, sound_enable, active_id, sound_signal}.
   task automatic exp_play(input logic [3:0] code, input logic [1:0] id, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back({1'b1, 1'b1, id, code});
   endtask

   task automatic exp_gap(input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(8'b1000_0000);
   endtask

   task automatic exp_idle(input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(8'b0000_0000);
   endtask

   task automatic tick();
      logic [7:0] want;
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
         want = exp_q.pop_front();
         check_eq(phase, {busy, sound_enable, active_id, sound_signal}, want);
      end
   endtask

   task automatic drain();
      while (exp_q.size() > 0) tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; sound_requests = 4'b0000; mute = 1'b0;
      phase = "reset";
      exp_idle(2);
      tick(); tick();
      reset = 1'b0;

      phase = "single";
      sound_requests = 4'b0001;
      exp_play(4'b0001, 2'd0, 8); exp_gap(2); exp_idle(2);
      tick(); sound_requests = 4'b0000; drain();

      phase = "preempt";
      sound_requests = 4'b0001;
      exp_play(4'b0001, 2'd0, 3);
      tick(); sound_requests = 4'b0000; tick(); tick();
      sound_requests = 4'b1000;
      exp_play(4'b1101, 2'd3, 8); exp_gap(2); exp_idle(2);
      tick(); sound_requests = 4'b0000; drain();

      phase = "queue";
      sound_requests = 4'b1000;
      exp_play(4'b1101, 2'd3, 8); exp_gap(2); exp_idle(1);
      exp_play(4'b0100, 2'd1, 8); exp_gap(2); exp_idle(1);
      exp_play(4'b0001, 2'd0, 8); exp_gap(2); exp_idle(2);
      tick(); sound_requests = 4'b0010;
      tick(); sound_requests = 4'b0001;
      tick(); sound_requests = 4'b0000;
      drain();

      phase = "hold";
      sound_requests = 4'b0100;
      exp_play(4'b1000, 2'd2, 8); exp_gap(2); exp_idle(10);
      repeat (20) tick();
      sound_requests = 4'b0000;
      exp_idle(2); drain();

      phase = "retrigger";
      sound_requests = 4'b0100;
      exp_play(4'b1000, 2'd2, 3);
      tick(); sound_requests = 4'b0000; tick(); tick();
      sound_requests = 4'b0100;
      exp_play(4'b1000, 2'd2, 8); exp_gap(2); exp_idle(2);
      tick(); sound_requests = 4'b0000; drain();

      phase = "mute";
      sound_requests = 4'b0010;
      exp_play(4'b0100, 2'd1, 2);
      tick(); sound_requests = 4'b0001;
      tick(); sound_requests = 4'b0000; mute = 1'b1;
      exp_idle(3);
      tick(); tick(); sound_requests = 4'b0100; tick();
      mute = 1'b0;
      exp_idle(14); drain();
      sound_requests = 4'b0000;

      phase = "reset_mid";
      sound_requests = 4'b0010;
      exp_play(4'b0100, 2'd1, 2);
      tick(); sound_requests = 4'b0001;
      tick(); sound_requests = 4'b0000; reset = 1'b1;
      exp_idle(1);
      tick(); reset = 1'b0;
      exp_idle(14); drain();

      phase = "gap_req";
      sound_requests = 4'b0100;
      exp_play(4'b1000, 2'd2, 8); exp_gap(2);
      tick(); sound_requests = 4'b0000;
      repeat (8) tick();
      sound_requests = 4'b0001;
      exp_idle(1); exp_play(4'b0001, 2'd0, 8); exp_gap(2); exp_idle(2);
      tick(); sound_requests = 4'b0000; drain();

      phase = "simultaneous";
      sound_requests = 4'b1111;
      exp_play(4'b1101, 2'd3, 8); exp_gap(2); exp_idle(1);
      exp_play(4'b1000, 2'd2, 8); exp_gap(2); exp_idle(1);
      exp_play(4'b0100, 2'd1, 8); exp_gap(2); exp_idle(1);
      exp_play(4'b0001, 2'd0, 8); exp_gap(2); exp_idle(2);
      tick(); sound_requests = 4'b0000; drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/sound_scheduler.md
Name: sound_scheduler

Overview:
Sequences the shared audio unit between all sound sources: keyboard fire, monster hit, spaceship hit and level-up.
- Captures asynchronous-in-time request edges and queues them per source.
- Plays one sound code at a time for a fixed duration, followed by a silent gap.
- A higher-priority request may preempt the sound currently playing.
- Sits between the game-logic request wires and the audio unit's 4-bit sound-select input.

Parameters:
NUM_REQUESTS, 4, number of requesters; index = priority (higher index wins)
DURATION_CYCLES, 25_000_000, clocks each sound is held (0.5 s at 50 MHz); must be >= 1
GAP_CYCLES, 2_500_000, silent clocks inserted after a sound completes; 0 allowed (no gap)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
sound_requests  input  NUM_REQUESTS  per-source request, level or pulse; rising edge = one request
mute  input  1  level; silences output and discards queue
sound_signal  output  4  sound code to audio unit; 0 = silence
sound_enable  output  1  high while a sound plays
active_id  output  $clog2(NUM_REQUESTS)  index of sound playing; 0 when idle
busy  output  1  high in PLAY or GAP

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. While reset is sampled high, at the next clk edge:
  - state=IDLE, counter=0, pending=0, req_prev=0;
  - sound_signal=0, sound_enable=0, active_id=0, busy=0.
  - Reset mid-PLAY or mid-GAP aborts immediately, with no residual pending.
- Edge detect: edge[i] = sound_requests[i] & ~req_prev[i]. req_prev updates every cycle. A held level produces one request only.
- Candidate set: cand = pending | edge. The selection is the highest set index of cand.
- Sound code per index comes from the package table SOUND_CODES:
  - 0 = MONSTER_HIT 4'b0001
  - 1 = FIRE 4'b0100
  - 2 = LEVEL_UP 4'b1000
  - 3 = SPACESHIP_HIT 4'b1101
- Outputs are registered.
- IDLE:
  - If cand != 0, at the same edge: state=PLAY, active_id=sel, sound_signal=SOUND_CODES[sel], sound_enable=1, busy=1, counter=DURATION_CYCLES-1, pending[sel] cleared, other cand bits kept in pending.
  - Latency: a request first sampled high at edge k gives a valid sound_signal after edge k.
- PLAY:
  - If counter==0: go to GAP with counter=GAP_CYCLES-1, or straight to IDLE if GAP_CYCLES==0. sound_signal=0, sound_enable=0, active_id=0. busy stays 1 in GAP and is 0 in IDLE.
  - Otherwise counter decrements.
  - New edge with index > active_id: preempt. Load the new id and code, reload counter to DURATION_CYCLES-1. The preempted sound is dropped, not re-queued.
  - New edge with index == active_id: retrigger. Reload counter; do not set pending.
  - New edge with index < active_id: set pending.
  - Several simultaneous edges: the highest index is acted on as above; the others set pending.
  - Preemption takes priority over expiry in the same cycle.
- GAP:
  - Output stays silent. Edges set pending only.
  - At counter==0 go to IDLE. A queued sound starts on the following edge, so there is 1 idle cycle between gap and next sound.
- mute (checked before all state logic):
  - While high: state=IDLE, pending=0, outputs as in reset. req_prev still tracks, so requests held across mute do not fire on unmute.
- Counter: unsigned, width $clog2(max(DURATION_CYCLES,GAP_CYCLES)+1). It never wraps, because a load always precedes any decrement from 0.
- Each pending bit is a single flag. Repeated lower-priority requests while busy collapse into one.

Decomposition:
- Shared package sound_pkg holds:
  - SOUND_WIDTH=4;
  - the sound code constants MONSTER_HIT_SOUND, FIRE_SOUND, LEVEL_UP_SOUND, SPACESHIP_HIT_SOUND;
  - the SOUND_CODES array;
  - the state enum {IDLE, PLAY, GAP}.
- One sub-module: sound_priority_encoder, parameterized by NUM_REQUESTS. It is combinational, takes cand, and outputs sel index and any_valid.

Test Plan (DURATION_CYCLES=8, GAP_CYCLES=2):
1. Single request: pulse sound_requests=4'b0001 for 1 cycle -> sound_signal=4'b0001 from the next cycle for exactly 8 cycles, then 2 cycles of 0 with busy=1, then busy=0.
2. Preemption: req[0] starts; on play cycle 3, pulse req[3] -> sound_signal=4'b1101 at the next edge for 8 full cycles. MONSTER_HIT does not resume.
3. Queueing: req[3] playing; pulse req[1] then req[0] -> after SPACESHIP 8 cycles + gap 2 + 1 idle cycle, FIRE 4'b0100 plays for 8 cycles, then gap, then MONSTER_HIT 4'b0001.
4. Level hold and retrigger: hold req[2] high for 20 cycles -> exactly one LEVEL_UP sound of 8 cycles. A second rising edge of req[2] during play extends it to 8 cycles from that edge.
5. Mute and reset mid-operation: assert mute during PLAY with req[0] pending -> next edge all outputs 0. After release nothing plays. Repeat with reset instead -> same result, and pending is empty.
6. Simultaneous: sound_requests 4'b0000->4'b1111 in one cycle from IDLE -> plays ids 3, 2, 1, 0 in order, each 8 cycles, separated by 2 gap cycles plus 1 idle cycle.
